// File: rtl/simmem_delay_releaser.sv
// Release side of a simulated-memory response bank.
// Each bank address (slot) receives a delay from the delay calculator, counts it
// down, then raises its release enable until the bank reports the release.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   entry_valid_i/ready_o, entry_iid_i, entry_delay_i
//                       delay entry handshake (ready is combinational)
//   stall_i             freezes all countdowns
//   release_en_o        multi-hot, slot may be released by the bank
//   released_onehot_i   one-hot, bank released that address this cycle
//   pending_o, busy_o   slot occupancy (COUNTING or RELEASABLE) and its OR
//   error_o             sticky protocol-violation flag
module simmem_delay_releaser #(
  parameter  int unsigned NumSlots = 8,
  parameter  int unsigned DelayW   = 8,
  localparam int unsigned IidW     = $clog2(NumSlots)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                entry_valid_i,
  output logic                entry_ready_o,
  input  logic [IidW-1:0]     entry_iid_i,
  input  logic [DelayW-1:0]   entry_delay_i,
  input  logic                stall_i,
  output logic [NumSlots-1:0] release_en_o,
  input  logic [NumSlots-1:0] released_onehot_i,
  output logic [NumSlots-1:0] pending_o,
  output logic                busy_o,
  output logic                error_o
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_COUNTING   = 2'd1,
    S_RELEASABLE = 2'd2
  } slot_state_e;

  logic [NumSlots-1:0] idle_vec;
  logic                accept;
  logic                wrong_release;
  logic                multi_release;
  logic                error_q;

  // Ready depends only on the addressed slot, never on valid.
  assign entry_ready_o = idle_vec[entry_iid_i];
  assign accept        = entry_valid_i && entry_ready_o;

  for (genvar k = 0; k < NumSlots; k++) begin : g_slot
    slot_state_e       state_q, state_d;
    logic [DelayW-1:0] cnt_q, cnt_d;
    logic              accept_k;

    assign accept_k = accept && (entry_iid_i == IidW'(k));

    // Slot state and counter register.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next state: the counter reaching 2 and decrementing marks the delay as elapsed.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        S_IDLE: begin
          if (accept_k) begin
            cnt_d   = entry_delay_i;
            state_d = (entry_delay_i > DelayW'(1)) ? S_COUNTING : S_RELEASABLE;
          end
        end
        S_COUNTING: begin
          if (!stall_i) begin
            if (cnt_q > DelayW'(1)) cnt_d = cnt_q - DelayW'(1);
            if (cnt_q <= DelayW'(2)) state_d = S_RELEASABLE;
          end
        end
        S_RELEASABLE: begin
          if (released_onehot_i[k]) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    assign idle_vec[k]     = (state_q == S_IDLE);
    assign release_en_o[k] = (state_q == S_RELEASABLE);
    assign pending_o[k]    = (state_q != S_IDLE);
  end

  assign busy_o = |pending_o;

  // Release pulses for non-releasable slots, or more than one pulse at once.
  assign wrong_release = |(released_onehot_i & ~release_en_o);
  assign multi_release = |(released_onehot_i & (released_onehot_i - NumSlots'(1)));

  // Sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) error_q <= 1'b0;
    else       error_q <= error_q | wrong_release | multi_release;
  end

  assign error_o = error_q;

endmodule

// File: tb/tb_simmem_delay_releaser.sv
module tb_simmem_delay_releaser;

  localparam int unsigned NumSlots = 8;
  localparam int unsigned DelayW   = 8;
  localparam int unsigned IidW     = 3;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                entry_valid_i;
  logic                entry_ready_o;
  logic [IidW-1:0]     entry_iid_i;
  logic [DelayW-1:0]   entry_delay_i;
  logic                stall_i;
  logic [NumSlots-1:0] release_en_o;
  logic [NumSlots-1:0] released_onehot_i;
  logic [NumSlots-1:0] pending_o;
  logic                busy_o;
  logic                error_o;

  int n_cmp = 0;
  int n_err = 0;

  simmem_delay_releaser #(.NumSlots(NumSlots), .DelayW(DelayW)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .entry_valid_i    (entry_valid_i),
    .entry_ready_o    (entry_ready_o),
    .entry_iid_i      (entry_iid_i),
    .entry_delay_i    (entry_delay_i),
    .stall_i          (stall_i),
    .release_en_o     (release_en_o),
    .released_onehot_i(released_onehot_i),
    .pending_o        (pending_o),
    .busy_o           (busy_o),
    .error_o          (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [IidW-1:0] iid, input logic [DelayW-1:0] dly);
    entry_valid_i = 1'b1;
    entry_iid_i   = iid;
    entry_delay_i = dly;
  endtask

  initial begin
    rst_i = 1'b1; entry_valid_i = 1'b0; entry_iid_i = '0; entry_delay_i = '0;
    stall_i = 1'b0; released_onehot_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Reset state
    chk("rst_release", 32'(release_en_o), 32'h00);
    chk("rst_pending", 32'(pending_o), 32'h00);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_error", 32'(error_o), 32'h0);
    chk("rst_ready", 32'(entry_ready_o), 32'h1);

    // iid 3, delay 5
    offer(3'd3, 8'd5);
    #1 chk("d5_ready", 32'(entry_ready_o), 32'h1);
    tick(); entry_valid_i = 1'b0;
    chk("d5_pending_t1", 32'(pending_o), 32'h08);
    chk("d5_busy_t1", 32'(busy_o), 32'h1);
    chk("d5_release_t1", 32'(release_en_o), 32'h00);
    tick(); tick(); tick();
    chk("d5_release_t4", 32'(release_en_o), 32'h00);
    tick();
    chk("d5_release_t5", 32'(release_en_o), 32'h08);
    tick();
    chk("d5_release_t6", 32'(release_en_o), 32'h08);
    #1 chk("d5_ready_busy_slot", 32'(entry_ready_o), 32'h0);
    released_onehot_i = 8'h08;
    tick(); released_onehot_i = '0;
    chk("d5_release_after", 32'(release_en_o), 32'h00);
    chk("d5_pending_after", 32'(pending_o), 32'h00);
    chk("d5_error", 32'(error_o), 32'h0);

    // Delays 0 and 1 in consecutive cycles
    offer(3'd0, 8'd0);
    tick();
    chk("d0_release", 32'(release_en_o), 32'h01);
    offer(3'd1, 8'd1);
    tick();
    chk("d1_release", 32'(release_en_o), 32'h03);

    // iid 2, delay 4, three stalled cycles; slots 0/1 stay releasable
    offer(3'd2, 8'd4);
    tick(); entry_valid_i = 1'b0; stall_i = 1'b1;
    chk("st_pending", 32'(pending_o), 32'h07);
    tick();
    chk("st_release_in_stall", 32'(release_en_o), 32'h03);
    tick(); tick(); stall_i = 1'b0;
    chk("st_release_b4", 32'(release_en_o), 32'h03);
    tick(); tick();
    chk("st_release_b6", 32'(release_en_o), 32'h03);
    tick();
    chk("st_release_b7", 32'(release_en_o), 32'h07);

    // Multi-hot release of slots 0 and 1
    released_onehot_i = 8'h03;
    tick(); released_onehot_i = '0;
    chk("mh_release", 32'(release_en_o), 32'h04);
    chk("mh_pending", 32'(pending_o), 32'h04);
    chk("mh_error", 32'(error_o), 32'h1);
    released_onehot_i = 8'h04;
    tick(); released_onehot_i = '0;
    chk("mh_release_s2", 32'(release_en_o), 32'h00);
    chk("mh_error_sticky", 32'(error_o), 32'h1);

    rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    chk("mid_rst_error", 32'(error_o), 32'h0);

    // Release of an idle slot
    released_onehot_i = 8'h40;
    tick(); released_onehot_i = '0;
    chk("idle_rel_error", 32'(error_o), 32'h1);
    chk("idle_rel_pending", 32'(pending_o), 32'h00);
    chk("idle_rel_release", 32'(release_en_o), 32'h00);
    tick();
    chk("idle_rel_error_held", 32'(error_o), 32'h1);

    // Offer to a counting slot, then re-accept after release
    offer(3'd5, 8'd3);
    tick();
    offer(3'd5, 8'd1);
    #1 chk("busy_ready", 32'(entry_ready_o), 32'h0);
    tick();
    chk("busy_no_accept", 32'(release_en_o), 32'h00);
    tick();
    chk("s5_release", 32'(release_en_o), 32'h20);
    released_onehot_i = 8'h20;
    #1 chk("s5_ready_rel_cycle", 32'(entry_ready_o), 32'h0);
    tick(); released_onehot_i = '0;
    chk("s5_release_gone", 32'(release_en_o), 32'h00);
    #1 chk("s5_ready_again", 32'(entry_ready_o), 32'h1);
    tick(); entry_valid_i = 1'b0;
    chk("s5_reaccept", 32'(release_en_o), 32'h20);
    released_onehot_i = 8'h20;
    tick(); released_onehot_i = '0;

    // Fill all slots, then reset mid-operation
    for (int i = 0; i < NumSlots; i++) begin
      offer(IidW'(i), 8'd200);
      tick();
    end
    entry_valid_i = 1'b0;
    chk("fill_pending", 32'(pending_o), 32'hFF);
    chk("fill_busy", 32'(busy_o), 32'h1);
    chk("fill_ready", 32'(entry_ready_o), 32'h0);
    rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    chk("frst_pending", 32'(pending_o), 32'h00);
    chk("frst_busy", 32'(busy_o), 32'h0);
    chk("frst_release", 32'(release_en_o), 32'h00);
    chk("frst_error", 32'(error_o), 32'h0);
    chk("frst_ready", 32'(entry_ready_o), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
